// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit BHT branch predictor with registered mispredict flush/redirect.
// Optional return-address stack selected by macro RAS_RETURN_PREDICT_EN.
module branch_predict_ctrl #(
  parameter int BHT_DEPTH = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_jal,
  input  logic        if_jalr,
  input  logic        if_B_type,
  input  logic [31:0] if_imme,
  input  logic [4:0]  if_rs1,
  input  logic [4:0]  if_rd,
  input  logic        stall,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc
);
  localparam int IW = $clog2(BHT_DEPTH);
  typedef enum logic {NORMAL, FLUSH} state_t;
  state_t r_state, w_next;
  logic [1:0] r_bht [BHT_DEPTH];
  logic [31:0] r_redirect;
  logic [IW-1:0] w_if_idx, w_ex_idx;
  logic [1:0] w_ctr, w_ctr_nxt;
  logic w_act, w_mis, w_upd_en, w_ras_hit;
  logic [31:0] w_ras_top;
  assign w_if_idx = if_pc[IW+1:2];
  assign w_ex_idx = ex_pc[IW+1:2];
  assign w_act = if_valid & (r_state == NORMAL);
  assign w_mis = (r_state == NORMAL) & ex_valid &
                 ((ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target)));
  assign w_upd_en = (r_state == NORMAL) & ex_valid & ex_branch;
  assign w_ctr = r_bht[w_ex_idx];
  assign w_ctr_nxt = ex_taken ? ((w_ctr == 2'd3) ? w_ctr : w_ctr + 2'd1)
                              : ((w_ctr == 2'd0) ? w_ctr : w_ctr - 2'd1);
  always_comb begin
    w_next = w_mis ? FLUSH : NORMAL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NORMAL;
      r_redirect <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else begin
      r_state <= w_next;
      if (w_mis) r_redirect <= ex_taken ? ex_target : ex_pc + 32'd4;
      if (w_upd_en) r_bht[w_ex_idx] <= w_ctr_nxt;
    end
  end
  // IF reads the pre-update counter; no bypass from the EX write
  assign pred_taken = w_act & (if_jal | w_ras_hit | (if_B_type & r_bht[w_if_idx][1]));
  assign pred_target = !pred_taken ? if_pc + 32'd4 :
                       (!if_jal && w_ras_hit) ? w_ras_top : if_pc + if_imme;
  assign flush = (r_state == FLUSH);
  assign redirect_pc = r_redirect;
`ifdef RAS_RETURN_PREDICT_EN
  localparam int RW = $clog2(RAS_DEPTH);
  logic [31:0] r_ras [RAS_DEPTH];
  logic [RW-1:0] r_ras_ptr;
  logic [RW:0] r_ras_cnt;
  logic w_push, w_pop;
  assign w_ras_hit = if_jalr & ((if_rs1 == 5'd1) | (if_rs1 == 5'd5)) & (if_rd == 5'd0) & (r_ras_cnt != '0);
  assign w_ras_top = r_ras[r_ras_ptr - RW'(1)];
  assign w_push = w_act & ~stall & if_jal & ((if_rd == 5'd1) | (if_rd == 5'd5));
  assign w_pop = w_act & ~stall & ~if_jal & w_ras_hit;
  // circular stack: a push when full silently overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (w_push) begin
      r_ras_ptr <= r_ras_ptr + RW'(1);
      r_ras_cnt <= (r_ras_cnt == (RW+1)'(RAS_DEPTH)) ? r_ras_cnt : r_ras_cnt + (RW+1)'(1);
    end else if (w_pop) begin
      r_ras_ptr <= r_ras_ptr - RW'(1);
      r_ras_cnt <= r_ras_cnt - (RW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_ras[r_ras_ptr] <= if_pc + 32'd4;
  end
`else
  logic w_unused;
  assign w_unused = ^{stall, if_jalr, if_rs1, if_rd};
  assign w_ras_hit = 1'b0;
  assign w_ras_top = '0;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed + randomized check of branch_predict_ctrl against a behavioural model.
module tb_branch_predict_ctrl;
  localparam int BD = 16;
  localparam int RD = 4;
  logic clk = 1'b0;
  logic rst, if_valid, if_jal, if_jalr, if_B_type, stall;
  logic [31:0] if_pc, if_imme;
  logic [4:0] if_rs1, if_rd;
  logic pred_taken, flush;
  logic [31:0] pred_target, redirect_pc;
  logic ex_valid, ex_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  int n_tests = 0;
  int n_fail = 0;
  int m_bht [BD];
  bit m_flush;
  logic [31:0] m_redir;
  logic [31:0] m_ras [$];

  branch_predict_ctrl #(.BHT_DEPTH(BD), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_jal(if_jal),
    .if_jalr(if_jalr), .if_B_type(if_B_type), .if_imme(if_imme), .if_rs1(if_rs1),
    .if_rd(if_rd), .stall(stall), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < BD; i++) m_bht[i] = 1;
    m_flush = 0;
    m_redir = '0;
    m_ras.delete();
  endtask

  task automatic idle();
    rst = 0; if_valid = 0; if_pc = '0; if_jal = 0; if_jalr = 0; if_B_type = 0;
    if_imme = '0; if_rs1 = '0; if_rd = '0; stall = 0;
    ex_valid = 0; ex_branch = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
    ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  function automatic bit ras_ok();
`ifdef RAS_RETURN_PREDICT_EN
    return if_jalr && (if_rs1 == 1 || if_rs1 == 5) && if_rd == 0 && m_ras.size() > 0;
`else
    return 0;
`endif
  endfunction

  // compare outputs for the inputs now applied, then advance the model across one edge
  task automatic step();
    bit act, et, hit, mis;
    logic [31:0] etg;
    int ei;
    #1;
    act = if_valid && !m_flush;
    et = 0; hit = 0; etg = if_pc + 4;
    if (act) begin
      if (if_jal) begin et = 1; etg = if_pc + if_imme; end
      else if (ras_ok()) begin et = 1; hit = 1; etg = m_ras[$]; end
      else if (if_B_type && m_bht[(if_pc >> 2) % BD] >= 2) begin et = 1; etg = if_pc + if_imme; end
    end
    check("pred_taken", {31'd0, pred_taken}, {31'd0, et});
    check("pred_target", pred_target, etg);
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("redirect_pc", redirect_pc, m_redir);
    @(posedge clk);
    if (rst) reset_model();
    else begin
      mis = !m_flush && ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
      if (!m_flush && ex_valid && ex_branch) begin
        ei = (ex_pc >> 2) % BD;
        m_bht[ei] = ex_taken ? ((m_bht[ei] == 3) ? 3 : m_bht[ei] + 1) : ((m_bht[ei] == 0) ? 0 : m_bht[ei] - 1);
      end
      if (mis) m_redir = ex_taken ? ex_target : ex_pc + 4;
`ifdef RAS_RETURN_PREDICT_EN
      if (act && !stall) begin
        if (if_jal && (if_rd == 1 || if_rd == 5)) begin
          m_ras.push_back(if_pc + 4);
          if (m_ras.size() > RD) void'(m_ras.pop_front());
        end else if (hit) void'(m_ras.pop_back());
      end
`endif
      m_flush = mis;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  function automatic logic [4:0] rand_reg();
    logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd2};
    return regs[$urandom_range(0, 3)];
  endfunction

  initial begin
    int k;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    reset_model();
    @(negedge clk);
    step();
    rst = 0;
    step();
    // weak not-taken after reset, then two taken resolutions make it taken
    if_valid = 1; if_B_type = 1; if_pc = 32'h40; if_imme = 32'h10;
    #1;
    check("bt_reset_taken", {31'd0, pred_taken}, 32'd0);
    check("bt_reset_target", pred_target, 32'h44);
    step();
    ex_valid = 1; ex_branch = 1; ex_pc = 32'h40; ex_taken = 1; ex_pred_taken = 1;
    ex_target = 32'h50; ex_pred_target = 32'h50;
    step();
    step();
    ex_valid = 0;
    #1;
    check("bt_trained_taken", {31'd0, pred_taken}, 32'd1);
    check("bt_trained_target", pred_target, 32'h50);
    step();
    // mispredict -> one FLUSH cycle with wrong-path EX ignored
    ex_valid = 1; ex_branch = 1; ex_pc = 32'h84; ex_taken = 1; ex_pred_taken = 0; ex_target = 32'h200;
    step();
    ex_pc = 32'h40; ex_taken = 0; ex_pred_taken = 1;
    #1;
    check("flush_set", {31'd0, flush}, 32'd1);
    check("flush_redirect", redirect_pc, 32'h200);
    check("flush_no_pred", {31'd0, pred_taken}, 32'd0);
    step();
    ex_valid = 0;
    #1;
    check("flush_clear", {31'd0, flush}, 32'd0);
    check("flush_no_bht_change", {31'd0, pred_taken}, 32'd1);
    step();
    // reset wins over a simultaneous mispredict
    rst = 1; ex_valid = 1; ex_pc = 32'h40; ex_taken = 1; ex_pred_taken = 0; ex_target = 32'h300;
    step();
    rst = 0; ex_valid = 0;
    #1;
    check("rst_mis_flush", {31'd0, flush}, 32'd0);
    check("rst_mis_redirect", redirect_pc, 32'h0);
    check("rst_mis_bht", {31'd0, pred_taken}, 32'd0);
    step();
    // jal always taken
    if_B_type = 0; if_jal = 1; if_pc = 32'h100; if_imme = 32'h80; if_rd = 0;
    #1;
    check("jal_taken", {31'd0, pred_taken}, 32'd1);
    check("jal_target", pred_target, 32'h180);
    step();
`ifdef RAS_RETURN_PREDICT_EN
    if_rd = 1;
    step();
    if_jal = 0; if_jalr = 1; if_rs1 = 1; if_rd = 0; if_pc = 32'h300;
    #1;
    check("ras_pop_taken", {31'd0, pred_taken}, 32'd1);
    check("ras_pop_target", pred_target, 32'h104);
    step();
    #1;
    check("ras_empty", {31'd0, pred_taken}, 32'd0);
    step();
    stall = 1; if_jalr = 0; if_jal = 1; if_rd = 1; if_pc = 32'h100;
    step();
    stall = 0; if_jal = 0; if_jalr = 1; if_rd = 0;
    #1;
    check("ras_stall_nopush", {31'd0, pred_taken}, 32'd0);
    step();
`else
    if_jal = 0; if_jalr = 1; if_rs1 = 1; if_rd = 0;
    #1;
    check("jalr_no_ras", {31'd0, pred_taken}, 32'd0);
    step();
`endif
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if_valid = ($urandom_range(0, 9) != 0);
      k = $urandom_range(0, 5);
      if_jal = (k == 0); if_jalr = (k == 1); if_B_type = (k >= 2 && k <= 4);
      if_pc = rand_pc();
      if_imme = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 255)) << 2;
      if_rs1 = rand_reg(); if_rd = rand_reg();
      stall = ($urandom_range(0, 4) == 0);
      ex_valid = ($urandom_range(0, 9) < 7);
      ex_branch = 1'($urandom_range(0, 1));
      ex_pc = rand_pc();
      ex_taken = 1'($urandom_range(0, 1));
      ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
      ex_target = rand_pc();
      ex_pred_target = ($urandom_range(0, 3) == 0) ? rand_pc() : ex_target;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
